// File: rtl/fp_norm_grs.sv
// fp_norm_grs: normalizes a wide unnormalized mantissa product into a truncated
// single-precision word plus guard/round/sticky, one item in flight, valid/ready both sides.
module fp_norm_grs #(
   parameter int M_W   = 48,
   parameter int EXP_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [M_W-1:0]   in_mant,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_word,
   output logic             out_guard,
   output logic             out_round,
   output logic             out_sticky
);
   typedef enum logic [1:0] {IDLE, NORM, DENORM, OUT} state_t;
   localparam logic signed [EXP_W:0]   E_ONE  = (EXP_W+1)'(1);
   localparam logic signed [EXP_W:0]   E_INF  = (EXP_W+1)'(255);
   localparam logic signed [EXP_W+1:0] UF_LIM = (EXP_W+2)'(M_W);
   state_t                  state, state_nx;
   logic [M_W-1:0]          w;
   logic signed [EXP_W:0]   e;
   logic                    sacc, sgn;
   logic signed [EXP_W:0]   e_load;
   logic signed [EXP_W+1:0] under_amt;
   logic                    accept, mant_zero, e_le0, full_uf;
   logic                    norm_shift, denorm_shift, pk_ovf;
   logic [31:0]             pk_word;
   logic                    pk_g, pk_r, pk_s;
   assign in_ready     = state == IDLE;
   assign out_valid    = state == OUT;
   assign accept       = in_valid && in_ready;
   assign mant_zero    = in_mant == '0;
   assign e_load       = {in_exp[EXP_W-1], in_exp} + (EXP_W+1)'(1);
   assign e_le0        = e_load[EXP_W] || e_load == '0;
   // right shifts needed to reach e==1; at M_W or more every bit lands in sticky
   assign under_amt    = (EXP_W+2)'(1) - {e_load[EXP_W], e_load};
   assign full_uf      = e_le0 && under_amt >= UF_LIM;
   assign norm_shift   = !w[M_W-1] && e > E_ONE;
   assign denorm_shift = e < E_ONE;
   assign pk_ovf       = e >= E_INF;
   assign pk_word      = pk_ovf ? {sgn, 8'hFF, 23'h0}
                                : {sgn, w[M_W-1] ? e[7:0] : 8'h00, w[M_W-2:M_W-24]};
   assign pk_g         = !pk_ovf && w[M_W-25];
   assign pk_r         = !pk_ovf && w[M_W-26];
   assign pk_s         = !pk_ovf && ((|w[M_W-27:0]) || sacc);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = (mant_zero || full_uf) ? OUT : e_le0 ? DENORM : NORM;
         NORM:    if (!norm_shift) state_nx = OUT;
         DENORM:  if (!denorm_shift) state_nx = OUT;
         OUT:     if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         w          <= '0;
         e          <= '0;
         sacc       <= 1'b0;
         sgn        <= 1'b0;
         out_word   <= '0;
         out_guard  <= 1'b0;
         out_round  <= 1'b0;
         out_sticky <= 1'b0;
      end else if (accept) begin
         w          <= in_mant;
         e          <= e_load;
         sacc       <= 1'b0;
         sgn        <= in_sign;
         // zero and full-underflow results are final here; other paths overwrite on pack
         out_word   <= {in_sign, 31'b0};
         out_guard  <= 1'b0;
         out_round  <= 1'b0;
         out_sticky <= !mant_zero && full_uf;
      end else if (state == NORM && norm_shift) begin
         w <= w << 1;
         e <= e - E_ONE;
      end else if (state == DENORM && denorm_shift) begin
         w    <= w >> 1;
         sacc <= sacc | w[0];
         e    <= e + E_ONE;
      end else if (state == NORM || state == DENORM) begin
         out_word   <= pk_word;
         out_guard  <= pk_g;
         out_round  <= pk_r;
         out_sticky <= pk_s;
      end
endmodule

// File: tb/tb_fp_norm_grs.sv
// tb_fp_norm_grs: directed table of hand-computed vectors plus stall and mid-flight reset sequences.
module tb_fp_norm_grs;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic        out_valid, out_ready;
   logic [31:0] out_word;
   logic        out_guard, out_round, out_sticky;
   int          tests = 0;
   int          fails = 0;
   typedef struct {
      logic [47:0] mant;
      logic [9:0]  exp;
      logic        sign;
      logic [31:0] word;
      logic [2:0]  grs;
      int          lat;
   } vec_t;
   vec_t tbl[15];
   fp_norm_grs #(.M_W(48), .EXP_W(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic launch(input logic [47:0] m, input logic [9:0] x, input logic s);
      @(negedge clk);
      in_valid = 1'b1; in_mant = m; in_exp = x; in_sign = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask
   task automatic drain(input string nm);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " valid_drop"}, out_valid, 1'b0);
      chk({nm, " ready_back"}, in_ready, 1'b1);
   endtask
   task automatic run_vec(input vec_t v, input string nm);
      int lat;
      launch(v.mant, v.exp, v.sign);
      wait_valid(lat);
      chk({nm, " lat"}, lat, v.lat);
      chk({nm, " word"}, out_word, v.word);
      chk({nm, " grs"}, {out_guard, out_round, out_sticky}, v.grs);
      chk({nm, " in_ready_out"}, in_ready, 1'b0);
      drain(nm);
   endtask
   initial begin
      int lat;
      logic [31:0] held;
      tbl[0]  = '{48'h6000_0000_0000, 10'sd127, 1'b0, 32'h3FC0_0000, 3'b000, 3};
      tbl[1]  = '{48'h8000_0000_0001, 10'sd127, 1'b0, 32'h4000_0000, 3'b001, 2};
      tbl[2]  = '{48'h0,              10'sd100, 1'b1, 32'h8000_0000, 3'b000, 1};
      tbl[3]  = '{48'h4000_0000_0000, -10'sd1,  1'b0, 32'h0020_0000, 3'b000, 3};
      tbl[4]  = '{48'h4000_0000_0000, 10'sd255, 1'b0, 32'h7F80_0000, 3'b000, 3};
      tbl[5]  = '{48'h4000_0000_0000, 10'sd255, 1'b1, 32'hFF80_0000, 3'b000, 3};
      tbl[6]  = '{48'h0000_0000_0001, -10'sd48, 1'b1, 32'h8000_0000, 3'b001, 1};
      tbl[7]  = '{48'h8000_0000_0000, -10'sd47, 1'b0, 32'h0000_0000, 3'b001, 49};
      tbl[8]  = '{48'h8000_00C0_0000, 10'sd127, 1'b0, 32'h4000_0000, 3'b110, 2};
      tbl[9]  = '{48'h8000_0080_0001, 10'sd127, 1'b0, 32'h4000_0000, 3'b101, 2};
      tbl[10] = '{48'h0000_0000_0001, 10'sd127, 1'b0, 32'h2880_0000, 3'b000, 49};
      tbl[11] = '{48'h1000_0000_0000, 10'sd0,   1'b0, 32'h0010_0000, 3'b000, 2};
      tbl[12] = '{48'h8000_0000_0001, -10'sd2,  1'b0, 32'h0020_0000, 3'b001, 4};
      tbl[13] = '{48'h8000_0000_0000, 10'sd300, 1'b0, 32'h7F80_0000, 3'b000, 2};
      tbl[14] = '{48'h8000_0000_0000, 10'sd253, 1'b1, 32'hFF00_0000, 3'b000, 2};
      rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", in_ready, 1'b1);
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset word", out_word, 32'h0);
      chk("reset grs", {out_guard, out_round, out_sticky}, 3'b000);
      @(negedge clk) rst_n = 1'b1;
      foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));
      // stall: result must hold and a waiting input must not be taken
      launch(48'h6000_0000_0000, 10'sd127, 1'b0);
      wait_valid(lat);
      chk("stall lat", lat, 3);
      held = out_word;
      @(negedge clk);
      in_valid = 1'b1; in_mant = 48'h8000_0000_0000; in_exp = 10'sd10; in_sign = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("stall%0d valid", c), out_valid, 1'b1);
         chk($sformatf("stall%0d word", c), out_word, 32'h3FC0_0000);
         chk($sformatf("stall%0d in_ready", c), in_ready, 1'b0);
      end
      chk("stall held", out_word, held);
      @(negedge clk) in_valid = 1'b0;
      drain("stall");
      // reset while 47 left shifts are still in progress
      launch(48'h0000_0000_0001, 10'sd127, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("midnorm busy", in_ready, 1'b0);
      chk("midnorm word pre", out_word, 32'h8000_0000);
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", out_valid, 1'b0);
      chk("midrst in_ready", in_ready, 1'b1);
      chk("midrst word", out_word, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      run_vec(tbl[0], "recover");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
